// File: rtl/fifo_sched_pkg.sv
// Shared types and helpers for the round-robin FIFO write scheduler.
package fifo_sched_pkg;

  typedef enum logic {IDLE, GRANT} sched_state_t;

  localparam int MAX_N = 8;
  localparam int PW    = $clog2(MAX_N);

  // Wraps at n, not at the power of two above it.
  function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] ptr, input int n);
    return (int'(ptr) >= n - 1) ? '0 : ptr + 3'd1;
  endfunction

endpackage

// File: rtl/fifo_wr_sched_rr_pick.sv
// Combinational rotate-priority picker: first set request at ptr, ptr+1, ... mod N.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           any,
  output logic [IDW-1:0] idx
);

  logic [IDW-1:0] j;

  // Scan from farthest to nearest so the nearest set bit wins.
  always_comb begin
    any = |req;
    idx = '0;
    j   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IDW'((int'(ptr) + k) % N);
      if (req[j]) idx = j;
    end
  end

endmodule

// File: rtl/fifo_wr_sched.sv
// Round-robin scheduler sharing one FIFO write port between N burst producers.
module fifo_wr_sched
  import fifo_sched_pkg::*;
#(
  parameter  int N         = 4,
  parameter  int WIDTH     = 32,
  parameter  int MAX_BURST = 4,
  localparam int IDW       = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rest,
  input  logic [N-1:0]         req_valid,
  input  logic [N-1:0]         req_last,
  input  logic [WIDTH-1:0]     req_data [N-1:0],
  output logic [N-1:0]         req_ready,
  input  logic                 flush,
  input  logic                 fifo_full,
  output logic                 fifo_write,
  output logic [IDW+WIDTH-1:0] fifo_write_data,
  output logic                 fifo_flush,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy
);

  localparam int BCW = $clog2(MAX_BURST) + 1;

  sched_state_t   state, state_d;
  logic [IDW-1:0] grant_d, rr_ptr, rr_d;
  logic [BCW-1:0] beat_cnt, cnt_d, cnt_inc;
  logic           pick_any, accept, burst_end;
  logic [IDW-1:0] pick_idx;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Flush overrides any beat that would otherwise be accepted this cycle.
  assign accept    = (state == GRANT) && !flush && req_valid[grant_id] && !fifo_full;
  assign cnt_inc   = beat_cnt + BCW'(1);
  assign burst_end = accept && (req_last[grant_id] || cnt_inc == BCW'(MAX_BURST));

  assign fifo_write      = accept;
  assign fifo_write_data = {grant_id, req_data[grant_id]};
  assign fifo_flush      = flush;
  assign busy            = (state == GRANT);

  always_comb begin
    req_ready = '0;
    if (state == GRANT && !flush) req_ready[grant_id] = !fifo_full;
  end

  always_comb begin
    state_d = state;
    grant_d = grant_id;
    rr_d    = rr_ptr;
    cnt_d   = beat_cnt;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state)
        IDLE: if (pick_any) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = GRANT;
        end
        GRANT: if (accept) begin
          cnt_d = cnt_inc;
          if (burst_end) begin
            state_d = IDLE;
            rr_d    = IDW'(rr_next(PW'(grant_id), N));
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_d;
      grant_id <= grant_d;
      rr_ptr   <= rr_d;
      beat_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_sched.sv
// Scoreboard bench for fifo_wr_sched: producer queues drive bursts, FIFO writes are checked in order.
module tb_fifo_wr_sched;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int MB  = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rest, flush, fifo_full;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [W-1:0]   req_data [N-1:0];
  logic           fifo_write, fifo_flush, busy;
  logic [IDW+W-1:0] fifo_write_data;
  logic [IDW-1:0] grant_id;

  fifo_wr_sched #(.N(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk             (clk),
    .rest            (rest),
    .req_valid       (req_valid),
    .req_last        (req_last),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .flush           (flush),
    .fifo_full       (fifo_full),
    .fifo_write      (fifo_write),
    .fifo_write_data (fifo_write_data),
    .fifo_flush      (fifo_flush),
    .grant_id        (grant_id),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W:0]       pmem [N][64];
  int               phead [N];
  int               ptail [N];
  logic [IDW+W-1:0] exp_q [$];
  int               wcyc [$];
  int               ewc [$];
  int               rel, full_lo, full_hi, flush_at, rest_at;
  bit               rst_hold;

  logic [N-1:0]     s_ready;
  logic             s_write, s_busy, s_flush;
  logic [IDW-1:0]   s_gid;
  logic [IDW+W-1:0] s_wdata;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int p, input int t, input int b, input bit last);
    logic [W-1:0] d;
    d = {8'(t), 8'(p), 16'(b)};
    pmem[p][ptail[p]] = {last, d};
    ptail[p]++;
    exp_q.push_back({IDW'(p), d});
  endtask

  function automatic bit pending();
    bit r = 1'b0;
    for (int i = 0; i < N; i++) if (phead[i] < ptail[i]) r = 1'b1;
    return r;
  endfunction

  task automatic tick();
    logic [N-1:0] acc;
    for (int i = 0; i < N; i++) begin
      if (phead[i] < ptail[i]) begin
        req_valid[i] = 1'b1;
        {req_last[i], req_data[i]} = pmem[i][phead[i]];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
        req_data[i]  = 32'hA5A5_0000 + W'(i);
      end
    end
    fifo_full = (rel >= full_lo) && (rel < full_hi);
    flush     = (rel == flush_at);
    rest      = rst_hold || (rel == rest_at);
    @(negedge clk);
    s_ready = req_ready; s_write = fifo_write; s_busy = busy;
    s_flush = fifo_flush; s_gid = grant_id; s_wdata = fifo_write_data;
    acc = req_valid & req_ready;
    if (fifo_write) begin
      wcyc.push_back(rel);
      if (exp_q.size() == 0) chk("spurious_write", 64'(fifo_write_data), 64'h1_dead_beef);
      else chk("wdata", 64'(fifo_write_data), 64'(exp_q.pop_front()));
    end
    if (fifo_full) chk("stall", {req_ready, fifo_write}, 0);
    if (flush) chk("flush_cycle", {fifo_flush, fifo_write, req_ready}, {1'b1, 1'b0, 4'b0});
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) phead[i]++;
    rel++;
  endtask

  task automatic begin_test();
    rel = 0; full_lo = -1; full_hi = -1; flush_at = -1; rest_at = -1;
    wcyc.delete(); ewc.delete();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((pending() || exp_q.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_drain"}, 64'(exp_q.size()), 0);
  endtask

  task automatic check_cyc(input string tag);
    chk({tag, "_nwr"}, 64'(wcyc.size()), 64'(ewc.size()));
    for (int i = 0; i < wcyc.size() && i < ewc.size(); i++)
      chk({tag, "_cyc"}, 64'(wcyc[i]), 64'(ewc[i]));
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin phead[i] = 0; ptail[i] = 0; end
    rst_hold = 1'b1;
    begin_test();
    tick(); tick();
    rst_hold = 1'b0;
    tick();
    chk("rst_busy", s_busy, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_write", s_write, 0);
    chk("rst_gid", s_gid, 0);
    chk("rst_wdata", s_wdata, {2'b0, 32'hA5A5_0000});
    chk("rst_flush", s_flush, 0);

    // 1: producers 1 and 3, two-beat bursts, one bubble between grants
    begin_test();
    push(1, 1, 0, 0); push(1, 1, 1, 1);
    push(3, 1, 0, 0); push(3, 1, 1, 1);
    drain("t1");
    ewc = '{1, 2, 4, 5};
    check_cyc("t1");
    // rr_ptr wrapped to 0: producer 0 beats producer 3
    begin_test();
    push(0, 2, 0, 1); push(3, 2, 0, 1);
    drain("t1b");
    ewc = '{1, 3};
    check_cyc("t1b");

    // 2: ten beats from producer 0 split 4,4,2
    begin_test();
    for (int b = 0; b < 10; b++) push(0, 3, b, b == 9);
    drain("t2");
    ewc = '{1, 2, 3, 4, 6, 7, 8, 9, 11, 12};
    check_cyc("t2");

    // 3: fifo_full for three cycles mid-burst; count must hold across the stall
    begin_test();
    full_lo = 3; full_hi = 6;
    for (int b = 0; b < 5; b++) push(2, 4, b, b == 4);
    drain("t3");
    ewc = '{1, 2, 6, 7, 9};
    check_cyc("t3");

    // 4: flush on the second beat; same producer regranted ahead of producer 2
    begin_test();
    flush_at = 2;
    for (int b = 0; b < 4; b++) push(1, 5, b, b == 3);
    push(2, 5, 0, 1);
    tick(); tick(); tick(); tick();
    chk("t4_idle_after_flush", s_busy, 0);
    drain("t4");
    ewc = '{1, 4, 5, 6, 8};
    check_cyc("t4");

    // 6: grant held while valid drops, then reset mid-grant
    begin_test();
    rest_at = 4;
    push(2, 6, 0, 0); push(2, 6, 1, 0);
    drain("t6");
    tick();
    chk("t6_held_busy", s_busy, 1);
    chk("t6_held_ready", s_ready, 4'b0100);
    chk("t6_held_gid", s_gid, 2);
    tick(); tick();
    chk("t6_rst_busy", s_busy, 0);
    chk("t6_rst_ready", s_ready, 0);
    chk("t6_rst_write", s_write, 0);
    chk("t6_rst_gid", s_gid, 0);
    chk("t6_rst_wdata", s_wdata, {2'b0, 32'hA5A5_0000});
    ewc = '{1, 2};
    check_cyc("t6");

    // 5: all producers with 1-beat bursts; rr_ptr=0 after reset
    begin_test();
    for (int b = 0; b < 2; b++)
      for (int p = 0; p < N; p++) push(p, 7, b, 1);
    drain("t5");
    ewc = '{1, 3, 5, 7, 9, 11, 13, 15};
    check_cyc("t5");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
